ec_scalar_mult_ctrl: RTL and testbench
======================================

Name: ec_scalar_mult_ctrl

Overview:
- Sequencer that computes R = k·P on y² = x³ + ax + b (mod prime) by left-to-right double-and-add.
- Sits directly upstream of the EC group-operation core (EC_TOP). It issues one add or double per operation over the core's in_valid/out_valid handshake and consumes the core's Rx/Ry.
- Handles the point at infinity itself, because the core cannot represent it.
- All field values are 6-bit. The core's latency is variable and is never assumed.

Parameters:
- WIDTH, 6, bit width of coordinates, prime, a and scalar k.
- CNT_W, 3, width of the bit-position counter; must satisfy 2^CNT_W ≥ WIDTH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous active-low.
- in_valid  in  1  one-cycle pulse; samples in_k, in_Px, in_Py, in_prime, in_a. Ignored unless in IDLE.
- in_k  in  WIDTH  scalar.
- in_Px, in_Py  in  WIDTH  base point P (on-curve, affine, coordinates < prime).
- in_prime  in  WIDTH  field prime.
- in_a  in  WIDTH  curve coefficient a.
- ec_in_valid  out  1  one-cycle pulse launching a core operation.
- ec_Px, ec_Py, ec_Qx, ec_Qy  out  WIDTH  core operands; registered and held stable from the pulse until ec_out_valid.
- ec_prime, ec_a  out  WIDTH  registered copies of in_prime and in_a.
- ec_out_valid  in  1  core result strobe.
- ec_Rx, ec_Ry  in  WIDTH  core result; valid only with ec_out_valid.
- out_valid  out  1  one-cycle result pulse.
- out_Rx, out_Ry  out  WIDTH  k·P. Forced to 0 whenever out_valid is low.
- out_inf  out  1  result is the point at infinity, with out_Rx = out_Ry = 0. Low whenever out_valid is low.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State returns to IDLE.
  - All outputs and registers go to 0; the infinity flag goes to 1.
  - Applies mid-operation too. Any ec_out_valid arriving afterwards in IDLE is ignored.
- States: IDLE, LOAD, DBL_ISSUE, DBL_WAIT, ADD_ISSUE, ADD_WAIT, NEXT, DONE.
- IDLE: on in_valid, register all inputs → LOAD.
- LOAD:
  - Priority-encode the MSB index m of k.
  - If k = 0: inf = 1 → DONE.
  - Otherwise: acc = P, inf = 0, bit counter = m.
  - Then go to NEXT if m > 0, else DONE.
- NEXT: decrement the counter to i → DBL_ISSUE.
- DBL_ISSUE:
  - If inf = 1, or acc.y = 0: inf = 1 and no core operation → ADD_ISSUE.
  - Otherwise: drive P = Q = acc, pulse ec_in_valid → DBL_WAIT.
- DBL_WAIT: on ec_out_valid, acc ← (ec_Rx, ec_Ry) → ADD_ISSUE.
- ADD_ISSUE: if bit k[i] = 0, skip directly to the loop test. Otherwise:
  - If inf = 1: acc = P, inf = 0, no core operation.
  - Else if acc.x = P.x and acc.y ≠ P.y: inf = 1, no core operation.
  - Otherwise: drive P = acc, Q = P, pulse ec_in_valid → ADD_WAIT. When acc = P this is a doubling, which the core detects.
- ADD_WAIT: on ec_out_valid, latch the result into acc.
- Loop test (after ADD_ISSUE/ADD_WAIT): i = 0 → DONE, else → NEXT.
- DONE:
  - Pulse out_valid for 1 cycle, with out_Rx/out_Ry = acc, or 0 and out_inf = 1 if inf.
  - → IDLE.
- Latency rules:
  - Exactly one ec_in_valid per core operation; never a second before ec_out_valid.
  - Number of core operations = m doublings + (popcount(k) − 1) adds, minus any skipped for infinity.
  - With zero core operations (k ∈ {0, 1}): in_valid sampled at edge T, out_valid high in cycle T+2.
- A stray ec_out_valid outside the WAIT states is ignored.
- All arithmetic is done by the core; this block only compares coordinates.

Test Plan:
All cases use prime = 17, a = 2 (b = 2), P = (5, 1), point order 19. Core model: reference EC_TOP, or a behavioural model with random 1–20 cycle latency.
- k = 1 → no ec_in_valid; out_valid in cycle T+2 with (5, 1), out_inf = 0.
- k = 0 → no ec_in_valid; out_valid in cycle T+2 with (0, 0), out_inf = 1.
- k = 2 → one operation with ec operands (5,1,5,1); result (6, 3).
- k = 5 → operation sequence dbl (5,1) → (6,3); dbl → (3,1); add (3,1)+(5,1) → (9,16). Output (9, 16); exactly 3 ec_in_valid pulses; operands stable throughout each wait.
- k = 19 → operations produce 2P, 4P, 8P, 9P = (7,6), then 18P = (5,16). The final add has equal x and unequal y, so no core operation is issued. 5 pulses total; output (0, 0) with out_inf = 1.
- Robustness:
  - rst_n low during DBL_WAIT of k = 5 → all outputs 0 next cycle; a late ec_out_valid causes no out_valid.
  - A new k = 2 request afterwards gives (6, 3).
  - in_valid pulsed mid-operation is ignored and the original result is unchanged.

Source files
------------

// File: rtl/ec_scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer computing k*P through an external EC group-operation core.
// The point at infinity is tracked here because the core has no encoding for it.
module ec_scalar_mult_ctrl #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_k,
    input  logic [WIDTH-1:0] in_Px,
    input  logic [WIDTH-1:0] in_Py,
    input  logic [WIDTH-1:0] in_prime,
    input  logic [WIDTH-1:0] in_a,
    output logic             ec_in_valid,
    output logic [WIDTH-1:0] ec_Px,
    output logic [WIDTH-1:0] ec_Py,
    output logic [WIDTH-1:0] ec_Qx,
    output logic [WIDTH-1:0] ec_Qy,
    output logic [WIDTH-1:0] ec_prime,
    output logic [WIDTH-1:0] ec_a,
    input  logic             ec_out_valid,
    input  logic [WIDTH-1:0] ec_Rx,
    input  logic [WIDTH-1:0] ec_Ry,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_Rx,
    output logic [WIDTH-1:0] out_Ry,
    output logic             out_inf
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_NEXT      = 3'd2,
        S_DBL_ISSUE = 3'd3,
        S_DBL_WAIT  = 3'd4,
        S_ADD_ISSUE = 3'd5,
        S_ADD_WAIT  = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Index of the most significant set bit; zero when no bit is set.
    function automatic logic [CNT_W-1:0] msb_index(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] idx;
        idx = {CNT_W{1'b0}};
        for (int j = 0; j < WIDTH; j++) begin
            if (v[j]) begin
                idx = CNT_W'(j);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] k_r, px_r, py_r;
    logic [WIDTH-1:0] acc_x_r, acc_y_r;
    logic             inf_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] ec_px_r, ec_py_r, ec_qx_r, ec_qy_r, ec_prime_r, ec_a_r;
    logic             ec_in_valid_r;
    logic             out_valid_r, out_inf_r;
    logic [WIDTH-1:0] out_rx_r, out_ry_r;

    logic             k_zero_s, dbl_skip_s, k_bit_s, add_neg_s, last_bit_s;
    logic [CNT_W-1:0] msb_s;
    logic             load_s, first_s, cnt_dec_s, dbl_go_s, dbl_inf_s;
    logic             core_res_s, add_take_p_s, add_inf_s, add_go_s, done_s;

    assign k_zero_s   = (k_r == ZERO_W);
    assign msb_s      = msb_index(k_r);
    assign dbl_skip_s = inf_r | (acc_y_r == ZERO_W);
    assign k_bit_s    = k_r[cnt_r];
    // acc = -P: the sum is infinity, which the core cannot return.
    assign add_neg_s  = (acc_x_r == px_r) && (acc_y_r != py_r);
    assign last_bit_s = (cnt_r == ZERO_C);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid) state_s = S_LOAD;
                else          state_s = S_IDLE;
            end
            S_LOAD: begin
                if (!k_zero_s && (msb_s != ZERO_C)) state_s = S_NEXT;
                else                                state_s = S_DONE;
            end
            S_NEXT: state_s = S_DBL_ISSUE;
            S_DBL_ISSUE: begin
                if (dbl_skip_s) state_s = S_ADD_ISSUE;
                else            state_s = S_DBL_WAIT;
            end
            S_DBL_WAIT: begin
                if (ec_out_valid) state_s = S_ADD_ISSUE;
                else              state_s = S_DBL_WAIT;
            end
            S_ADD_ISSUE: begin
                if (k_bit_s && !inf_r && !add_neg_s) state_s = S_ADD_WAIT;
                else if (last_bit_s)                 state_s = S_DONE;
                else                                 state_s = S_NEXT;
            end
            S_ADD_WAIT: begin
                if (!ec_out_valid)   state_s = S_ADD_WAIT;
                else if (last_bit_s) state_s = S_DONE;
                else                 state_s = S_NEXT;
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Per-state datapath strobes.
    always_comb begin
        load_s       = 1'b0;
        first_s      = 1'b0;
        cnt_dec_s    = 1'b0;
        dbl_go_s     = 1'b0;
        dbl_inf_s    = 1'b0;
        core_res_s   = 1'b0;
        add_take_p_s = 1'b0;
        add_inf_s    = 1'b0;
        add_go_s     = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            S_IDLE:      load_s    = in_valid;
            S_LOAD:      first_s   = 1'b1;
            S_NEXT:      cnt_dec_s = 1'b1;
            S_DBL_ISSUE: begin
                if (dbl_skip_s) dbl_inf_s = 1'b1;
                else            dbl_go_s  = 1'b1;
            end
            S_DBL_WAIT:  core_res_s = ec_out_valid;
            S_ADD_ISSUE: begin
                if (!k_bit_s)       add_go_s     = 1'b0;
                else if (inf_r)     add_take_p_s = 1'b1;
                else if (add_neg_s) add_inf_s    = 1'b1;
                else                add_go_s     = 1'b1;
            end
            S_ADD_WAIT:  core_res_s = ec_out_valid;
            S_DONE:      done_s     = 1'b1;
            default:     done_s     = 1'b0;
        endcase
    end

    // Operand capture, accumulator, bit counter and core operand registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_r           <= ZERO_W;
            px_r          <= ZERO_W;
            py_r          <= ZERO_W;
            ec_prime_r    <= ZERO_W;
            ec_a_r        <= ZERO_W;
            acc_x_r       <= ZERO_W;
            acc_y_r       <= ZERO_W;
            inf_r         <= 1'b1;
            cnt_r         <= ZERO_C;
            ec_in_valid_r <= 1'b0;
            ec_px_r       <= ZERO_W;
            ec_py_r       <= ZERO_W;
            ec_qx_r       <= ZERO_W;
            ec_qy_r       <= ZERO_W;
        end else begin
            ec_in_valid_r <= dbl_go_s | add_go_s;
            if (load_s) begin
                k_r        <= in_k;
                px_r       <= in_Px;
                py_r       <= in_Py;
                ec_prime_r <= in_prime;
                ec_a_r     <= in_a;
            end else begin
                k_r <= k_r;
            end
            if (first_s) begin
                acc_x_r <= px_r;
                acc_y_r <= py_r;
                inf_r   <= k_zero_s;
                cnt_r   <= msb_s;
            end else if (cnt_dec_s) begin
                cnt_r <= cnt_r - ONE_C;
            end else if (dbl_inf_s || add_inf_s) begin
                inf_r <= 1'b1;
            end else if (add_take_p_s) begin
                acc_x_r <= px_r;
                acc_y_r <= py_r;
                inf_r   <= 1'b0;
            end else if (core_res_s) begin
                acc_x_r <= ec_Rx;
                acc_y_r <= ec_Ry;
            end else begin
                acc_x_r <= acc_x_r;
            end
            if (dbl_go_s) begin
                ec_px_r <= acc_x_r;
                ec_py_r <= acc_y_r;
                ec_qx_r <= acc_x_r;
                ec_qy_r <= acc_y_r;
            end else if (add_go_s) begin
                ec_px_r <= acc_x_r;
                ec_py_r <= acc_y_r;
                ec_qx_r <= px_r;
                ec_qy_r <= py_r;
            end else begin
                ec_px_r <= ec_px_r;
            end
        end
    end

    // Result registers; cleared in every cycle that is not the result pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_inf_r   <= 1'b0;
            out_rx_r    <= ZERO_W;
            out_ry_r    <= ZERO_W;
        end else begin
            out_valid_r <= done_s;
            out_inf_r   <= done_s & inf_r;
            if (done_s && !inf_r) begin
                out_rx_r <= acc_x_r;
                out_ry_r <= acc_y_r;
            end else begin
                out_rx_r <= ZERO_W;
                out_ry_r <= ZERO_W;
            end
        end
    end

    assign ec_in_valid = ec_in_valid_r;
    assign ec_Px       = ec_px_r;
    assign ec_Py       = ec_py_r;
    assign ec_Qx       = ec_qx_r;
    assign ec_Qy       = ec_qy_r;
    assign ec_prime    = ec_prime_r;
    assign ec_a        = ec_a_r;
    assign out_valid   = out_valid_r;
    assign out_Rx      = out_rx_r;
    assign out_Ry      = out_ry_r;
    assign out_inf     = out_inf_r;

endmodule

// File: tb/tb_ec_scalar_mult_ctrl.sv
// Bench for ec_scalar_mult_ctrl: behavioural EC core with random latency and a repeated-addition k*P model.
module tb_ec_scalar_mult_ctrl;
    localparam int W  = 6;
    localparam int PR = 17;
    localparam int AC = 2;
    localparam int PX = 5;
    localparam int PY = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_k, in_Px, in_Py, in_prime, in_a;
    logic         ec_in_valid;
    logic [W-1:0] ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a;
    logic         ec_out_valid;
    logic [W-1:0] ec_Rx, ec_Ry;
    logic         out_valid;
    logic [W-1:0] out_Rx, out_Ry;
    logic         out_inf;

    always #5 clk = ~clk;

    ec_scalar_mult_ctrl #(.WIDTH(W), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_k(in_k),
        .in_Px(in_Px), .in_Py(in_Py), .in_prime(in_prime), .in_a(in_a),
        .ec_in_valid(ec_in_valid), .ec_Px(ec_Px), .ec_Py(ec_Py),
        .ec_Qx(ec_Qx), .ec_Qy(ec_Qy), .ec_prime(ec_prime), .ec_a(ec_a),
        .ec_out_valid(ec_out_valid), .ec_Rx(ec_Rx), .ec_Ry(ec_Ry),
        .out_valid(out_valid), .out_Rx(out_Rx), .out_Ry(out_Ry), .out_inf(out_inf)
    );

    int checks = 0;
    int errors = 0;
    int op_count = 0;
    int overlap_err = 0;
    int stable_err = 0;
    int core_busy = 0;
    int core_cnt = 0;
    int core_aborted = 0;
    int cap_px, cap_py, cap_qx, cap_qy, res_x, res_y, res_inf;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int modn(input int v);
        return ((v % PR) + PR) % PR;
    endfunction

    function automatic int inv(input int v);
        for (int i = 1; i < PR; i++) begin
            if (modn(v * i) == 1) return i;
        end
        return 0;
    endfunction

    // Affine group law with an explicit infinity flag.
    task automatic ec_add(input int x1, input int y1, input int i1,
                          input int x2, input int y2, input int i2,
                          output int x3, output int y3, output int i3);
        int lam;
        if (i1 != 0) begin
            x3 = x2; y3 = y2; i3 = i2;
        end else if (i2 != 0) begin
            x3 = x1; y3 = y1; i3 = i1;
        end else if (x1 == x2 && modn(y1 + y2) == 0) begin
            x3 = 0; y3 = 0; i3 = 1;
        end else begin
            if (x1 == x2 && y1 == y2) lam = modn((3 * x1 * x1 + AC) * inv(modn(2 * y1)));
            else                      lam = modn(modn(y2 - y1) * inv(modn(x2 - x1)));
            x3 = modn(lam * lam - x1 - x2);
            y3 = modn(lam * (x1 - x3) - y1);
            i3 = 0;
        end
    endtask

    task automatic model_kp(input int k, output int x, output int y, output int inf);
        int tx, ty, ti;
        x = 0; y = 0; inf = 1;
        for (int j = 0; j < k; j++) begin
            ec_add(x, y, inf, PX, PY, 0, tx, ty, ti);
            x = tx; y = ty; inf = ti;
        end
    endtask

    // Behavioural core: random 1..20 cycle latency, checks operand stability and single issue.
    initial begin
        ec_out_valid = 1'b0;
        ec_Rx = '0;
        ec_Ry = '0;
        forever begin
            @(posedge clk); #1;
            ec_out_valid = 1'b0;
            if (rst_n !== 1'b1) core_aborted = 1;
            if (core_busy != 0) begin
                if (core_aborted == 0 &&
                    (int'(ec_Px) != cap_px || int'(ec_Py) != cap_py ||
                     int'(ec_Qx) != cap_qx || int'(ec_Qy) != cap_qy)) stable_err++;
                if (core_cnt == 0) begin
                    ec_out_valid = 1'b1;
                    ec_Rx = W'(res_x);
                    ec_Ry = W'(res_y);
                    core_busy = 0;
                    core_aborted = 0;
                end else begin
                    core_cnt--;
                end
            end
            if (ec_in_valid === 1'b1) begin
                op_count++;
                if (core_busy != 0) overlap_err++;
                cap_px = int'(ec_Px); cap_py = int'(ec_Py);
                cap_qx = int'(ec_Qx); cap_qy = int'(ec_Qy);
                ec_add(cap_px, cap_py, 0, cap_qx, cap_qy, 0, res_x, res_y, res_inf);
                core_busy = 1;
                core_cnt = $urandom_range(0, 19);
            end
        end
    end

    task automatic run_k(input int k, input int glitch_at,
                         output int ox, output int oy, output int oinf,
                         output int lat, output int ops);
        int n, ops0;
        @(negedge clk);
        in_k = W'(k); in_Px = W'(PX); in_Py = W'(PY);
        in_prime = W'(PR); in_a = W'(AC);
        in_valid = 1'b1;
        ops0 = op_count;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 3000) begin
            if (n == glitch_at) begin
                in_k = W'(2);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        lat = n;
        ox = int'(out_Rx); oy = int'(out_Ry); oinf = int'(out_inf);
        ops = op_count - ops0;
        check("out_valid_seen", int'(out_valid), 1);
        @(posedge clk); #1;
        check("pulse_one_cycle", int'(out_valid), 0);
        check("rx_zero_idle", int'(out_Rx) + int'(out_inf), 0);
    endtask

    initial begin
        int ox, oy, oi, lat, ops, ex, ey, ei, k, n, seen;
        rst_n = 1'b0; in_valid = 1'b0;
        in_k = '0; in_Px = '0; in_Py = '0; in_prime = '0; in_a = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_inf", int'(out_inf), 0);
        check("rst_ec_in_valid", int'(ec_in_valid), 0);
        check("rst_ec_prime", int'(ec_prime), 0);
        rst_n = 1'b1;

        run_k(1, -1, ox, oy, oi, lat, ops);
        check("k1_lat", lat, 2); check("k1_x", ox, 5); check("k1_y", oy, 1);
        check("k1_inf", oi, 0); check("k1_ops", ops, 0);

        run_k(0, -1, ox, oy, oi, lat, ops);
        check("k0_lat", lat, 2); check("k0_x", ox, 0); check("k0_y", oy, 0);
        check("k0_inf", oi, 1); check("k0_ops", ops, 0);

        run_k(2, -1, ox, oy, oi, lat, ops);
        check("k2_x", ox, 6); check("k2_y", oy, 3); check("k2_inf", oi, 0);
        check("k2_ops", ops, 1);
        check("k2_operands", cap_px * 1000 + cap_py * 100 + cap_qx * 10 + cap_qy, 5151);
        check("ec_prime_copy", int'(ec_prime), PR);
        check("ec_a_copy", int'(ec_a), AC);

        run_k(5, -1, ox, oy, oi, lat, ops);
        check("k5_x", ox, 9); check("k5_y", oy, 16); check("k5_inf", oi, 0);
        check("k5_ops", ops, 3);

        run_k(19, -1, ox, oy, oi, lat, ops);
        check("k19_x", ox, 0); check("k19_y", oy, 0); check("k19_inf", oi, 1);
        check("k19_ops", ops, 5);

        // Reset while the first doubling of k = 5 is outstanding.
        @(negedge clk);
        in_k = W'(5); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (ec_in_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_issue_seen", int'(ec_in_valid), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_ec_in_valid", int'(ec_in_valid), 0);
        check("abort_ec_ops", int'(ec_Px) + int'(ec_Py) + int'(ec_Qx) + int'(ec_Qy), 0);
        check("abort_out", int'(out_valid) + int'(out_Rx) + int'(out_Ry) + int'(out_inf), 0);
        check("abort_ec_prime", int'(ec_prime), 0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        check("abort_no_out_valid", seen, 0);

        run_k(2, -1, ox, oy, oi, lat, ops);
        check("post_rst_k2_x", ox, 6); check("post_rst_k2_y", oy, 3);

        run_k(5, 4, ox, oy, oi, lat, ops);
        check("glitch_k5_x", ox, 9); check("glitch_k5_y", oy, 16);
        check("glitch_k5_ops", ops, 3);

        for (int r = 0; r < 12; r++) begin
            k = $urandom_range(0, 63);
            model_kp(k, ex, ey, ei);
            run_k(k, -1, ox, oy, oi, lat, ops);
            check($sformatf("rand_k%0d_x", k), ox, ex);
            check($sformatf("rand_k%0d_y", k), oy, ey);
            check($sformatf("rand_k%0d_inf", k), oi, ei);
        end

        check("no_overlapping_issue", overlap_err, 0);
        check("operands_stable", stable_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
